serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Transmit-side counterpart of the team's serial "101" Moore sequence detector.
- Accepts a parallel word over a valid/ready handshake and serializes it, one bit per clock, as a frame on a single line:
  - sync pattern 1,0,1,
  - DATA_W payload bits, MSB first,
  - optional even-parity bit,
  - GUARD_BITS zeros.
- The guard zeros return a downstream detector to its reset state between frames. The line idles at 0.

Parameters:
- DATA_W, 8: payload width in bits; must be ≥ 1.
- PARITY_EN, 1: 1 inserts an even-parity bit after the payload; 0 omits it.
- GUARD_BITS, 2: number of trailing 0 bits per frame; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  payload word; sampled on accept.
- tx_valid  input  1  producer has a word on tx_data.
- tx_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial line; registered.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values (on a clk edge with reset=1): data_out=0, busy=0, frame_done=0, state=IDLE, shift register and counters cleared.
  - tx_ready is forced 0 while reset=1.
- Handshake:
  - tx_ready = 1 exactly when state==IDLE and reset==0 (combinational from state).
  - An accept occurs on an edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register at that edge; parity is computed at the same edge as XOR of tx_data.
  - tx_valid while busy is ignored; no word is lost as long as the producer holds tx_valid until it sees tx_ready.
- States: IDLE, SYNC, DATA, PAR, GUARD. A bit counter indexes within SYNC, DATA and GUARD.
- Transitions:
  - IDLE → SYNC on accept.
  - SYNC: 3 cycles, data_out = 1, 0, 1 → DATA.
  - DATA: DATA_W cycles, MSB first.
  - DATA → PAR if PARITY_EN, else → GUARD.
  - PAR: 1 cycle.
  - GUARD: GUARD_BITS cycles of 0 → IDLE.
- Latency: accept at edge N drives the first sync bit (1) on data_out from edge N onward, i.e. during cycle N+1. Each line bit is valid for exactly one cycle.
- Frame length L = 3 + DATA_W + PARITY_EN + GUARD_BITS (13 at defaults).
- frame_done is asserted for one cycle, the first IDLE cycle after the last guard bit. tx_ready is high in that same cycle.
  - With tx_valid held high, consecutive frames start every L+1 cycles; the line is 0 for that idle cycle.
- busy = 1 from the first sync bit through the last guard bit inclusive.
- In IDLE, data_out = 0.
- Reset mid-frame: the frame is abandoned at the reset edge and data_out returns to 0 the same edge. frame_done is not pulsed, and no partial word is retransmitted.
- No bit-stuffing: payload may legitimately contain 1,0,1. The receiver frames on the first detection after idle only.
- Counters are sized to clog2(max(DATA_W, GUARD_BITS, 3)) + 1 bits. No wrap-around is reachable in legal operation.

Test Plan:
- Reset, then tx_data=8'hA5 with tx_valid held 1 cycle → data_out = 1,0,1, 1,0,1,0,0,1,0,1, 0, 0,0; busy high 13 cycles; frame_done pulses once in cycle 14; tx_ready low cycles 1–13.
- tx_data=8'h01 → payload 0,0,0,0,0,0,0,1, parity bit 1; feed the line into the "101" detector → detected asserts after the sync bits, and the detector is in S0 after the two guard zeros.
- tx_valid held high with words 8'hFF then 8'h00 → second sync starts exactly 14 cycles after the first (one idle 0 between frames); parity bits 0 and 0.
- Assert reset for 1 cycle during payload bit 4 of 8'h5A → data_out=0, busy=0, tx_ready=1 the next cycle, no frame_done; a following 8'h3C frame transmits correctly.
- PARITY_EN=0, DATA_W=4, GUARD_BITS=3, tx_data=4'hB → line 1,0,1, 1,0,1,1, 0,0,0; frame length 10.
- tx_valid pulsed while busy, with tx_data changed mid-frame → transmitted bits and parity unaffected; the pulse is not accepted.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Transmit-side partner of the serial "101" Moore sequence detector.
// The block accepts a parallel word over a valid/ready handshake and sends it
// on a single line, one bit per clock, as a frame:
//   sync 1,0,1 | DATA_W payload bits MSB first | optional even parity | GUARD_BITS zeros
// The trailing zeros return a downstream detector to its reset state. The line
// idles at 0.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high reset
//   tx_data    - payload word, captured when a word is accepted
//   tx_valid   - producer has a word on tx_data
//   tx_ready   - block can accept a word this cycle (IDLE and not in reset)
//   data_out   - registered serial line
//   busy       - frame in progress (any state other than IDLE)
//   frame_done - one-cycle pulse in the first IDLE cycle after a frame
module serial_pattern_tx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int GUARD_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              data_out,
    output logic              busy,
    output logic              frame_done
);

    // One counter indexes the sync, payload and guard bits, so it is sized
    // for the longest of the three.
    localparam int MAX_LEN = (DATA_W > GUARD_BITS) ? ((DATA_W > 3) ? DATA_W : 3)
                                                   : ((GUARD_BITS > 3) ? GUARD_BITS : 3);
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] GUARD = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic [CNT_W-1:0]  bit_cnt;
    logic              accept;

    // Ready is purely a function of state so the producer sees it in the
    // same cycle; it is held low while reset is asserted.
    assign tx_ready = (state == IDLE) && !reset;
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);

    // Frame sequencer. data_out is loaded with the bit that belongs to the
    // state being entered, so the state register always names the bit that is
    // currently on the line. The shift register presents the next payload bit
    // at its MSB and is shifted as each bit is sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            data_out   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    data_out <= 1'b0;
                    if (accept) begin
                        state      <= SYNC;
                        shift_reg  <= tx_data;
                        parity_bit <= ^tx_data;
                        bit_cnt    <= '0;
                        data_out   <= 1'b1;
                    end
                end
                SYNC: begin
                    if (bit_cnt == SYNC_LAST) begin
                        state     <= DATA;
                        bit_cnt   <= '0;
                        data_out  <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                    end else begin
                        // Sync bit 1 is 0, sync bit 2 is 1.
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        data_out <= (bit_cnt == CNT_W'(1));
                    end
                end
                DATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt <= '0;
                        if (PARITY_EN != 0) begin
                            state    <= PAR;
                            data_out <= parity_bit;
                        end else begin
                            state    <= GUARD;
                            data_out <= 1'b0;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        data_out  <= shift_reg[DATA_W-1];
                        shift_reg <= shift_reg << 1;
                    end
                end
                PAR: begin
                    state    <= GUARD;
                    bit_cnt  <= '0;
                    data_out <= 1'b0;
                end
                GUARD: begin
                    data_out <= 1'b0;
                    if (bit_cnt == GUARD_LAST) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx
// Bench for serial_pattern_tx. A default-parameter instance is checked
// against a per-cycle scoreboard: when the bench decides a word is accepted it
// pushes the whole expected frame (line bit, busy, frame_done, tx_ready per
// cycle) and the monitor pops one entry per cycle. A second instance with
// DATA_W=4, PARITY_EN=0, GUARD_BITS=3 is checked against a fixed bit table.
module tb_serial_pattern_tx;

    localparam int DATA_W     = 8;
    localparam int GUARD_BITS = 2;
    localparam int FRAME_LEN  = 3 + DATA_W + 1 + GUARD_BITS;

    typedef struct packed {
        logic line;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       data_out;
    logic       busy;
    logic       frame_done;

    logic [3:0] tx_data4;
    logic       tx_valid4;
    logic       tx_ready4;
    logic       data_out4;
    logic       busy4;
    logic       frame_done4;

    exp_t expQ[$];
    int   checkCount;
    int   passCount;
    int   acceptCount;
    bit   monitorOn;
    int   cycleCount;
    int   lastRise;
    int   lastGap;
    logic prevBusy;
    int   frameIdx;
    logic [1:0] detState;
    int   detCount;
    int   lastDetIdx;

    serial_pattern_tx #(.DATA_W(8), .PARITY_EN(1), .GUARD_BITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    serial_pattern_tx #(.DATA_W(4), .PARITY_EN(0), .GUARD_BITS(3)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data4),
        .tx_valid   (tx_valid4),
        .tx_ready   (tx_ready4),
        .data_out   (data_out4),
        .busy       (busy4),
        .frame_done (frame_done4)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, observed, expected, cycleCount);
        end
    endtask

    // Expected frame from the bench's own model of the line format, followed
    // by the idle cycle that carries frame_done.
    function automatic void pushFrame(input logic [7:0] word);
        logic [2:0] syncBits;
        syncBits = 3'b101;
        for (int i = 2; i >= 0; i--) expQ.push_back('{syncBits[i], 1'b1, 1'b0, 1'b0});
        for (int i = 7; i >= 0; i--) expQ.push_back('{word[i], 1'b1, 1'b0, 1'b0});
        expQ.push_back('{^word, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < GUARD_BITS; i++) expQ.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        expQ.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
    endfunction

    // Accept model: the bench considers the block idle once the previous
    // frame's entries have all been consumed; reset abandons the frame.
    always @(posedge clk) begin
        cycleCount++;
        if (reset) begin
            expQ.delete();
        end else if (tx_valid && expQ.size() == 0) begin
            pushFrame(tx_data);
            acceptCount++;
        end
    end

    // Per-cycle monitor on the falling edge, plus a "101" Moore detector fed
    // from the line and a recorder for frame start spacing.
    always @(negedge clk) begin
        if (monitorOn) begin
            exp_t e;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
            end else begin
                e = '{1'b0, 1'b0, 1'b0, !reset};
            end
            checkOutput("data_out", {31'd0, data_out}, {31'd0, e.line});
            checkOutput("busy", {31'd0, busy}, {31'd0, e.busy});
            checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.done});
            checkOutput("tx_ready", {31'd0, tx_ready}, {31'd0, e.ready});

            if (busy && !prevBusy) begin
                lastGap  = cycleCount - lastRise;
                lastRise = cycleCount;
                frameIdx = 0;
            end else begin
                frameIdx++;
            end
            prevBusy = busy;

            case (detState)
                2'd0: detState = data_out ? 2'd1 : 2'd0;
                2'd1: detState = data_out ? 2'd1 : 2'd2;
                2'd2: detState = data_out ? 2'd3 : 2'd0;
                default: detState = data_out ? 2'd1 : 2'd2;
            endcase
            if (detState == 2'd3) begin
                detCount++;
                lastDetIdx = frameIdx;
            end
        end
    end

    // Wait (bounded) for the model to register one more accepted word.
    task automatic waitAccept();
        int start;
        bit got;
        start = acceptCount;
        got   = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (acceptCount != start) got = 1;
        end
        checkOutput("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    // Present one word, hold valid until accepted, then drop valid.
    task automatic applyStimulus(input logic [7:0] word);
        @(posedge clk);
        #1;
        tx_data  = word;
        tx_valid = 1'b1;
        waitAccept();
        tx_valid = 1'b0;
    endtask

    // Wait (bounded) until the expected frame has been fully observed.
    task automatic waitIdle();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0) done = 1;
        end
        checkOutput("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        logic [10:0] line4;
        int          detBefore;
        checkCount  = 0;
        passCount   = 0;
        acceptCount = 0;
        monitorOn   = 0;
        cycleCount  = 0;
        lastRise    = 0;
        lastGap     = 0;
        prevBusy    = 1'b0;
        frameIdx    = 0;
        detState    = 2'd0;
        detCount    = 0;
        lastDetIdx  = -1;
        reset       = 1'b1;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        tx_data4    = 4'h0;
        tx_valid4   = 1'b0;

        // Reset state is checked by the monitor while reset is still high.
        @(posedge clk);
        #1;
        monitorOn = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] single frame 8'hA5");
        applyStimulus(8'hA5);
        waitIdle();

        $display("[TB] frame 8'h01 through 101 detector");
        detBefore = detCount;
        applyStimulus(8'h01);
        waitIdle();
        checkOutput("det_count", detCount - detBefore, 32'd1);
        checkOutput("det_index", lastDetIdx, 32'd2);
        checkOutput("det_state_s0", {30'd0, detState}, 32'd0);

        $display("[TB] back-to-back 8'hFF then 8'h00");
        @(posedge clk);
        #1;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        waitAccept();
        tx_data = 8'h00;
        waitAccept();
        tx_valid = 1'b0;
        waitIdle();
        checkOutput("frame_spacing", lastGap, FRAME_LEN + 1);

        $display("[TB] reset during payload bit 4 of 8'h5A");
        applyStimulus(8'h5A);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        applyStimulus(8'h3C);
        waitIdle();

        $display("[TB] valid pulsed mid-frame with changing data");
        applyStimulus(8'hC3);
        repeat (5) @(posedge clk);
        #1;
        tx_data  = 8'h7E;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h11;
        waitIdle();
        checkOutput("accept_total", acceptCount, 32'd7);

        $display("[TB] DATA_W=4, no parity, 3 guard bits, 4'hB");
        line4 = 11'b1011011_0000;
        @(posedge clk);
        #1;
        tx_data4  = 4'hB;
        tx_valid4 = 1'b1;
        @(negedge clk);
        checkOutput("ready4", {31'd0, tx_ready4}, 32'd1);
        @(posedge clk);
        #1;
        tx_valid4 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checkOutput("line4", {31'd0, data_out4}, {31'd0, line4[10-i]});
            checkOutput("busy4", {31'd0, busy4}, {31'd0, (i < 10)});
            checkOutput("done4", {31'd0, frame_done4}, {31'd0, (i == 10)});
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
